// File: rtl/div_32_seq_pkg.sv
// Shared definitions for the multdiv unit's iterative divider.
//   - FSM state encoding and iteration count.
//   - Carry-select adder and two's-complement helpers. Trial subtraction and
//     sign fix-up both use them, so the divider shares one adder style.
package div_32_seq_pkg;

   localparam int DIV_ITER = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // 33-bit carry-select add. The low 17 bits ripple.
   // The high 16 bits are precomputed for both carry-in values.
   // The carry out of the low half then selects one of them.
   function automatic logic [32:0] csa_add(input logic [32:0] a,
                                           input logic [32:0] b,
                                           input logic        cin);
      logic [17:0] lo;
      logic [15:0] hi0;
      logic [15:0] hi1;
      lo  = {1'b0, a[16:0]} + {1'b0, b[16:0]} + {17'd0, cin};
      hi0 = a[32:17] + b[32:17];
      hi1 = a[32:17] + b[32:17] + 16'd1;
      return {(lo[17] ? hi1 : hi0), lo[16:0]};
   endfunction

   // Two's-complement negate as ~x + 1 through the adder. It wraps, so
   // negating 0x80000000 gives 0x80000000.
   function automatic logic [31:0] neg32(input logic [31:0] x);
      logic        unused_carry;
      logic [31:0] res;
      {unused_carry, res} = csa_add({1'b0, ~x}, 33'd0, 1'b1);
      return res;
   endfunction

   // Unsigned magnitude of a signed value.
   function automatic logic [31:0] abs32(input logic [31:0] x);
      return x[31] ? neg32(x) : x;
   endfunction

endpackage

// File: rtl/div_32_seq_sub_step.sv
// div_sub_step: one restoring-division trial subtraction.
//   rem_shifted [32:0] in  : partial remainder after the left shift
//   divisor     [31:0] in  : divisor magnitude
//   diff        [32:0] out : rem_shifted - divisor, 33-bit two's complement
//   ge                 out : 1 when the difference is non-negative
module div_sub_step
   import div_32_seq_pkg::*;
(
   input  logic [32:0] rem_shifted,
   input  logic [31:0] divisor,
   output logic [32:0] diff,
   output logic        ge
);

   // Subtraction is done as an add of ~{0,divisor} with carry-in 1.
   assign diff = csa_add(rem_shifted, ~{1'b0, divisor}, 1'b1);
   assign ge   = ~diff[32];

endmodule

// File: rtl/div_32_seq.sv
// div_32_seq: iterative signed 32-bit divider (restoring, one bit per cycle).
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   ctrl_DIV       : start pulse; operands are captured in the same cycle
//   data_operandA  : dividend (two's complement)
//   data_operandB  : divisor (two's complement)
//   data_result    : quotient, held until the next completion
//   data_remainder : remainder, sign follows the dividend
//   data_exception : divide-by-zero or 0x80000000 / -1 overflow
//   data_resultRDY : one-cycle completion pulse
//   busy           : set while an operation is in RUN or DONE
// All outputs are registered, so they follow the FSM by one cycle.
module div_32_seq
   import div_32_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   state_t             state, state_next;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   rem, quo, abs_b;
   logic               neg_q, neg_r, exc;

   logic               b_zero, overflow;
   logic [WIDTH:0]     rem_shifted, step_diff;
   logic               step_ge;
   logic [WIDTH-1:0]   quo_fixed, rem_fixed;
   logic               unused_diff_msb;

   assign b_zero   = (data_operandB == '0);
   assign overflow = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);

   // The next dividend bit shifts into the remainder. rem < |B| <= 2^31, so
   // this shifted value always fits in 33 bits.
   assign rem_shifted = {rem, quo[WIDTH-1]};

   div_sub_step u_step (
      .rem_shifted (rem_shifted),
      .divisor     (abs_b),
      .diff        (step_diff),
      .ge          (step_ge)
   );

   // A non-negative trial difference fits in the low 32 bits. Its sign bit
   // is already available as step_ge.
   assign unused_diff_msb = step_diff[WIDTH];

   assign quo_fixed = neg_q ? neg32(quo) : quo;
   assign rem_fixed = neg_r ? neg32(rem) : rem;

   // NOTE: state_next gets a default before the case, so paths that do not
   // assign it do not infer a latch.
   always_comb begin
      state_next = state;
      if (ctrl_DIV) begin
         // A start pulse wins in every state. It aborts a running operation.
         state_next = b_zero ? S_DONE : S_RUN;
      end else begin
         case (state)
            S_RUN:   if (count == CNT_W'(DIV_ITER - 1)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // NOTE: all sequential state uses non-blocking assignments. Every
   // register then samples pre-edge values, whatever the statement order.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count          <= '0;
         rem            <= '0;
         quo            <= '0;
         abs_b          <= '0;
         neg_q          <= 1'b0;
         neg_r          <= 1'b0;
         exc            <= 1'b0;
         data_result    <= '0;
         data_remainder <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= (state == S_DONE);
         busy           <= (state != S_IDLE);

         // The finishing result is published even if a new start arrives
         // in the same cycle.
         if (state == S_DONE) begin
            data_result    <= quo_fixed;
            data_remainder <= rem_fixed;
            data_exception <= exc;
         end

         if (ctrl_DIV) begin
            abs_b <= abs32(data_operandB);
            neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            neg_r <= data_operandA[WIDTH-1];
            exc   <= b_zero | overflow;
            count <= '0;
            rem   <= '0;
            quo   <= b_zero ? '0 : abs32(data_operandA);
         end else if (state == S_RUN) begin
            rem   <= step_ge ? step_diff[WIDTH-1:0] : rem_shifted[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], step_ge};
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq. A reference model pushes the expected
// result and completion cycle into a scoreboard each time an op starts.
// A monitor pops and compares on each data_resultRDY pulse.
module tb_div_32_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic [31:0] data_result, data_remainder;
   logic        data_exception, data_resultRDY, busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        exc;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   div_32_seq dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_remainder (data_remainder),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // The model uses 64-bit signed division. It truncates toward zero, so
   // the remainder takes the dividend's sign. The low 32 bits give the
   // wrapped 0x80000000 / -1 quotient.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int rdy_cyc);
      exp_t   e;
      longint sa, sbv, q, r;
      e.cyc = rdy_cyc;
      if (b == 32'd0) begin
         e.q = '0; e.r = '0; e.exc = 1'b1;
      end else begin
         sa  = longint'($signed(a));
         sbv = longint'($signed(b));
         q   = sa / sbv;
         r   = sa % sbv;
         e.q = q[31:0];
         e.r = r[31:0];
         e.exc = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      end
      return e;
   endfunction

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clock);
         if (data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_rdy at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               n_tests++;
               if (cyc !== e.cyc) begin
                  n_fail++; $display("FAIL rdy_cycle got %0d want %0d", cyc, e.cyc);
               end
               n_tests++;
               if (data_result !== e.q) begin
                  n_fail++; $display("FAIL result got %h want %h", data_result, e.q);
               end
               n_tests++;
               if (data_remainder !== e.r) begin
                  n_fail++; $display("FAIL remainder got %h want %h", data_remainder, e.r);
               end
               n_tests++;
               if (data_exception !== e.exc) begin
                  n_fail++; $display("FAIL exception got %b want %b", data_exception, e.exc);
               end
            end
         end
      end
   endtask

   // Drives a one-cycle start pulse, sampled at the next edge (cyc+1).
   // With replace set, the op in flight is aborted, so its expected
   // result is dropped first.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit replace);
      int edge_n;
      @(negedge clock);
      edge_n = cyc + 1;
      if (replace && sb.size() != 0) void'(sb.pop_back());
      sb.push_back(model(a, b, edge_n + ((b == 32'd0) ? 1 : 33)));
      ctrl_DIV = 1'b1; data_operandA = a; data_operandB = b;
      @(negedge clock);
      ctrl_DIV = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL completion_timeout pending %0d after %0d cycles", sb.size(), budget);
         sb.delete();
      end
      @(negedge clock);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clock);
   endtask

   task automatic check_all_zero(input string tag);
      n_tests++;
      if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== 67'd0) begin
         n_fail++;
         $display("FAIL %s got q=%h r=%h exc=%b rdy=%b busy=%b want all zero",
                  tag, data_result, data_remainder, data_exception, data_resultRDY, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check_all_zero("reset_state");
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_basic();
      int s;
      start_op(32'd100, 32'd7, 0);
      s = cyc;
      wait_until(s + 33);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL busy_at_rdy got %b want 1", busy);
      end
      wait_until(s + 34);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL busy_after_rdy got %b want 0", busy);
      end
      wait_done(10);
      start_op(32'hFFFF_FF9C, 32'd7, 0);
      wait_done(50);
      start_op(32'd7, 32'hFFFF_FFFE, 0);
      wait_done(50);
      start_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);
      wait_done(50);
      start_op(32'd5, 32'd9, 0);
      wait_done(50);
      start_op(32'h7FFF_FFFF, 32'h8000_0000, 0);
      wait_done(50);
   endtask

   task automatic test_div_zero();
      start_op(32'd12345, 32'd0, 0);
      wait_done(10);
      start_op(32'h8000_0000, 32'd0, 0);
      wait_done(10);
   endtask

   task automatic test_overflow();
      start_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
      wait_done(50);
      start_op(32'h8000_0000, 32'd1, 0);
      wait_done(50);
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         start_op(a, b, 0);
         wait_done(50);
      end
   endtask

   task automatic test_abort();
      int s;
      start_op(32'd1000, 32'd10, 0);
      s = cyc;
      wait_until(s + 9);
      start_op(32'd9, 32'd3, 1);
      wait_done(60);
   endtask

   task automatic test_back_to_back();
      int s;
      start_op(32'd77, 32'd5, 0);
      s = cyc;
      wait_until(s + 32);
      start_op(32'hFFFF_FC18, 32'd33, 0);
      wait_done(80);
   endtask

   task automatic test_reset_mid();
      int s;
      start_op(32'd5000, 32'd3, 0);
      s = cyc;
      wait_until(s + 14);
      reset = 1'b1;
      sb.delete();
      @(negedge clock);
      check_all_zero("reset_mid_op");
      reset = 1'b0;
      repeat (40) @(negedge clock);
      start_op(32'd5000, 32'd3, 0);
      wait_done(50);
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_div_zero();
      test_overflow();
      test_random();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      repeat (40) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
